// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU register-file write path.
package cpu_pkg;

  localparam int REG_N     = 8;
  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic              valid;
    reg_idx_t          rw;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Decode a register index into its scoreboard bit.
  function automatic logic [REG_N-1:0] onehot(input reg_idx_t idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/cpu_wr_arbiter.sv
// Two-way arbiter for the single register-file write port. A (execute result)
// wins by default; B (load return) takes priority once it has been denied
// STARVE_MAX cycles in a row, which bounds its latency.
module cpu_wr_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_a_valid,
  input  logic [REG_IDX_W-1:0] i_a_rw,
  input  logic [DATA_W-1:0]    i_a_data,
  input  logic                 i_b_valid,
  input  logic [REG_IDX_W-1:0] i_b_rw,
  input  logic [DATA_W-1:0]    i_b_data,
  output logic                 grant_a,
  output logic                 grant_b,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_rw,
  output logic [DATA_W-1:0]    wr_data
);

  // Legal STARVE_MAX values (1..3) fit the 2-bit counter.
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  logic [1:0] starve_cnt_q;
  logic [1:0] starve_cnt_d;
  logic       b_prio;

  // Grant selection, write-port mux and next starvation count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    b_prio       = (starve_cnt_q == STARVE_LIM);
    grant_b      = ~reset & i_b_valid & (~i_a_valid | b_prio);
    grant_a      = ~reset & i_a_valid & ~grant_b;
    wr_en        = grant_a | grant_b;
    wr_rw        = '0;
    wr_data      = '0;
    starve_cnt_d = '0;
    if (grant_a) begin
      wr_rw   = i_a_rw;
      wr_data = i_a_data;
    end else if (grant_b) begin
      wr_rw   = i_b_rw;
      wr_data = i_b_data;
    end
    // Count only consecutive denials; a grant or an idle B restarts it.
    if (i_b_valid && !grant_b) begin
      starve_cnt_d = b_prio ? starve_cnt_q : starve_cnt_q + 2'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_rf_scheduler.sv
// Write-port scheduler and hazard scoreboard for the 8x16 register file.
// Arbitrates A/B writebacks onto the single write port, tracks registers with
// an in-flight write and stalls issue on RAW/WAW hazards.
module cpu_rf_scheduler
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_iss_valid,
  input  logic [REG_IDX_W-1:0] i_iss_rx,
  input  logic [REG_IDX_W-1:0] i_iss_ry,
  input  logic                 i_iss_rx_used,
  input  logic                 i_iss_ry_used,
  input  logic [REG_IDX_W-1:0] i_iss_rw,
  input  logic                 i_iss_wen,
  output logic                 o_iss_stall,
  input  logic                 i_a_valid,
  input  logic [REG_IDX_W-1:0] i_a_rw,
  input  logic [DATA_W-1:0]    i_a_data,
  output logic                 o_a_ready,
  input  logic                 i_b_valid,
  input  logic [REG_IDX_W-1:0] i_b_rw,
  input  logic [DATA_W-1:0]    i_b_data,
  output logic                 o_b_ready,
  output logic [REG_IDX_W-1:0] o_rw,
  output logic [DATA_W-1:0]    o_rw_data,
  output logic                 o_rw_en,
  output logic [REG_N-1:0]     o_pending,
  output logic                 o_err
);

  logic [REG_N-1:0] pending_q;
  logic [REG_N-1:0] pending_d;
  logic             err_q;
  logic             err_d;
  logic [REG_N-1:0] clr;
  logic [REG_N-1:0] set;
  logic [REG_N-1:0] eff;

  cpu_wr_arbiter #(
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_a_valid (i_a_valid),
    .i_a_rw    (i_a_rw),
    .i_a_data  (i_a_data),
    .i_b_valid (i_b_valid),
    .i_b_rw    (i_b_rw),
    .i_b_data  (i_b_data),
    .grant_a   (o_a_ready),
    .grant_b   (o_b_ready),
    .wr_en     (o_rw_en),
    .wr_rw     (o_rw),
    .wr_data   (o_rw_data)
  );

  // Hazard detection and scoreboard next state. A register whose write
  // completes this cycle is not a hazard: the register file forwards it.
  always_comb begin
    clr         = o_rw_en ? onehot(o_rw) : '0;
    eff         = pending_q & ~clr;
    o_iss_stall = reset |
                  (i_iss_valid & ((i_iss_rx_used & eff[i_iss_rx]) |
                                  (i_iss_ry_used & eff[i_iss_ry]) |
                                  (i_iss_wen     & eff[i_iss_rw])));
    set         = (i_iss_valid & i_iss_wen & ~o_iss_stall) ? onehot(i_iss_rw) : '0;
    // Set is applied after clear so a same-cycle issue to a completing
    // register leaves it pending.
    pending_d   = eff | set;
    err_d       = err_q | (o_rw_en & ~pending_q[o_rw]);
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign o_pending = pending_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_cpu_rf_scheduler.sv
// Directed self-checking bench for cpu_rf_scheduler (STARVE_MAX = 2).
module tb_cpu_rf_scheduler;
  import cpu_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 iss_valid, iss_rx_used, iss_ry_used, iss_wen;
  logic [REG_IDX_W-1:0] iss_rx, iss_ry, iss_rw;
  logic                 iss_stall;
  wr_req_t              a_req, b_req;
  logic                 a_ready, b_ready;
  logic [REG_IDX_W-1:0] rw;
  logic [DATA_W-1:0]    rw_data;
  logic                 rw_en;
  logic [REG_N-1:0]     pending;
  logic                 err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  cpu_rf_scheduler #(
    .DATA_W     (DATA_W),
    .STARVE_MAX (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_iss_valid   (iss_valid),
    .i_iss_rx      (iss_rx),
    .i_iss_ry      (iss_ry),
    .i_iss_rx_used (iss_rx_used),
    .i_iss_ry_used (iss_ry_used),
    .i_iss_rw      (iss_rw),
    .i_iss_wen     (iss_wen),
    .o_iss_stall   (iss_stall),
    .i_a_valid     (a_req.valid),
    .i_a_rw        (a_req.rw),
    .i_a_data      (a_req.data),
    .o_a_ready     (a_ready),
    .i_b_valid     (b_req.valid),
    .i_b_rw        (b_req.rw),
    .i_b_data      (b_req.data),
    .o_b_ready     (b_ready),
    .o_rw          (rw),
    .o_rw_data     (rw_data),
    .o_rw_en       (rw_en),
    .o_pending     (pending),
    .o_err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss_idle();
    iss_valid = 1'b0; iss_wen = 1'b0; iss_rx_used = 1'b0; iss_ry_used = 1'b0;
    iss_rx = '0; iss_ry = '0; iss_rw = '0;
  endtask

  // Present an instruction that only writes rd.
  task automatic iss_write(input logic [2:0] rd);
    iss_idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rw = rd;
  endtask

  initial begin
    reset = 1'b1;
    iss_idle();
    a_req = '0;
    b_req = '0;
    tick();
    #1;
    check("rst_stall", 32'(iss_stall), 32'd1);
    check("rst_rw_en", 32'(rw_en), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_pending", 32'(pending), 32'h00);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_rw", 32'(rw), 32'd0);
    check("post_rst_rw_data", 32'(rw_data), 32'd0);
    check("post_rst_stall", 32'(iss_stall), 32'd0);

    // Issue a write to r3; no hazard in the issue cycle.
    iss_write(3'd3);
    #1;
    check("iss_r3_stall", 32'(iss_stall), 32'd0);
    tick();
    iss_idle();
    #1;
    check("iss_r3_pending", 32'(pending), 32'h08);

    // RAW on r3 stalls, then same-cycle completion by A removes it.
    iss_valid = 1'b1; iss_rx = 3'd3; iss_rx_used = 1'b1;
    #1;
    check("raw_r3_stall", 32'(iss_stall), 32'd1);
    a_req = '{valid: 1'b1, rw: 3'd3, data: 16'hBEEF};
    #1;
    check("fwd_r3_stall", 32'(iss_stall), 32'd0);
    check("fwd_r3_rw_en", 32'(rw_en), 32'd1);
    check("fwd_r3_rw", 32'(rw), 32'd3);
    check("fwd_r3_data", 32'(rw_data), 32'hBEEF);
    check("fwd_r3_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_req = '0;
    iss_idle();
    #1;
    check("fwd_r3_pending", 32'(pending), 32'h00);
    check("fwd_r3_err", 32'(err), 32'd0);

    // Set wins over clear on the same index (r5).
    iss_write(3'd5);
    tick();
    a_req = '{valid: 1'b1, rw: 3'd5, data: 16'h1234};
    #1;
    check("setclr_stall", 32'(iss_stall), 32'd0);
    check("setclr_a_ready", 32'(a_ready), 32'd1);
    tick();
    iss_idle();
    #1;
    check("setclr_pending", 32'(pending), 32'h20);
    a_req = '{valid: 1'b1, rw: 3'd5, data: 16'h5678};
    tick();
    a_req = '0;
    #1;
    check("r5_done_pending", 32'(pending), 32'h00);
    check("r5_done_err", 32'(err), 32'd0);

    // ry RAW, unused rx, WAW; then lone B completes r1.
    iss_write(3'd1);
    tick();
    iss_idle();
    iss_valid = 1'b1; iss_ry = 3'd1; iss_ry_used = 1'b1;
    #1;
    check("raw_ry_stall", 32'(iss_stall), 32'd1);
    iss_idle();
    iss_valid = 1'b1; iss_rx = 3'd1; iss_rx_used = 1'b0;
    #1;
    check("rx_unused_stall", 32'(iss_stall), 32'd0);
    iss_write(3'd1);
    #1;
    check("waw_stall", 32'(iss_stall), 32'd1);
    iss_write(3'd1);
    iss_rw = 3'd1;
    tick();
    iss_idle();
    #1;
    check("waw_pending", 32'(pending), 32'h02);
    b_req = '{valid: 1'b1, rw: 3'd1, data: 16'hCAFE};
    #1;
    check("b_alone_ready", 32'(b_ready), 32'd1);
    check("b_alone_data", 32'(rw_data), 32'hCAFE);
    tick();
    b_req = '0;
    #1;
    check("b_alone_pending", 32'(pending), 32'h00);

    // Write to a non-pending register sets the sticky error.
    a_req = '{valid: 1'b1, rw: 3'd2, data: 16'h0BAD};
    #1;
    check("err_write_en", 32'(rw_en), 32'd1);
    check("err_before", 32'(err), 32'd0);
    tick();
    a_req = '0;
    #1;
    check("err_set", 32'(err), 32'd1);

    // Continuous A and B traffic: A, A, B, A, A, B.
    b_req = '{valid: 1'b1, rw: 3'd6, data: 16'h6666};
    for (int k = 0; k < 6; k++) begin
      logic exp_b;
      exp_b = (k == 2) || (k == 5);
      a_req = '{valid: 1'b1, rw: 3'd4, data: 16'(16'h4000 + k)};
      #1;
      check($sformatf("arb_a_%0d", k), 32'(a_ready), 32'(!exp_b));
      check($sformatf("arb_b_%0d", k), 32'(b_ready), 32'(exp_b));
      check($sformatf("arb_rw_%0d", k), 32'(rw), exp_b ? 32'd6 : 32'd4);
      tick();
    end
    // Counter restarted after the last B grant: next cycle A wins again.
    #1;
    check("arb_after_a", 32'(a_ready), 32'd1);
    check("arb_after_b", 32'(b_ready), 32'd0);
    b_req = '0;
    a_req = '0;
    tick();
    check("err_sticky", 32'(err), 32'd1);

    // Build pending = 8'hA5, then reset mid-traffic.
    iss_write(3'd0); tick();
    iss_write(3'd2); tick();
    iss_write(3'd5); tick();
    iss_write(3'd7); tick();
    iss_idle();
    #1;
    check("a5_pending", 32'(pending), 32'hA5);
    reset = 1'b1;
    a_req = '{valid: 1'b1, rw: 3'd0, data: 16'hAAAA};
    b_req = '{valid: 1'b1, rw: 3'd2, data: 16'hBBBB};
    #1;
    check("mid_rst_a_ready", 32'(a_ready), 32'd0);
    check("mid_rst_b_ready", 32'(b_ready), 32'd0);
    check("mid_rst_rw_en", 32'(rw_en), 32'd0);
    check("mid_rst_stall", 32'(iss_stall), 32'd1);
    tick();
    reset = 1'b0;
    a_req = '0;
    b_req = '0;
    #1;
    check("mid_rst_pending", 32'(pending), 32'h00);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_rw", 32'(rw), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cpu_rf_scheduler.md
# cpu_rf_scheduler

Write-port scheduler and hazard scoreboard for the CPU's 8×16-bit general-purpose register file, which has one write port. It shares that port between two writeback requesters: A, the execute-stage result, and B, the memory load return. It tracks which registers have an in-flight write and raises an issue stall on RAW/WAW hazards. It sits between the decode/issue stage, the writeback sources and `cpu_register_file`'s `i_rw`/`i_rw_data`/`i_rw_en` inputs.

## Interface
Parameters:
- `DATA_W`, 16, register data width
- `STARVE_MAX`, 2, consecutive denied cycles of B after which B takes priority over A (1..3)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `i_iss_valid`  in  1  instruction presented for issue
- `i_iss_rx`, `i_iss_ry`  in  3  source register indices
- `i_iss_rx_used`, `i_iss_ry_used`  in  1  source actually read
- `i_iss_rw`  in  3  destination index
- `i_iss_wen`  in  1  instruction writes `i_iss_rw`
- `o_iss_stall`  out  1  issue must hold this cycle
- `i_a_valid`, `i_a_rw`, `i_a_data`  in  1/3/DATA_W  requester A write
- `o_a_ready`  out  1  A granted this cycle
- `i_b_valid`, `i_b_rw`, `i_b_data`  in  1/3/DATA_W  requester B write
- `o_b_ready`  out  1  B granted this cycle
- `o_rw`, `o_rw_data`, `o_rw_en`  out  3/DATA_W/1  register-file write port
- `o_pending`  out  8  scoreboard, bit i set means a write to ri is in flight
- `o_err`  out  1  sticky error: a write was granted to a non-pending register

## Operation
- Arbiter priority:
  - A wins by default.
  - B wins when `starve_cnt == STARVE_MAX`.
  - If only one requester is valid, it wins.
  - At most one grant per cycle.
- Write port: `o_rw_en` = either grant; `o_rw`/`o_rw_data` are muxed from the winner. With no grant, `o_rw` and `o_rw_data` are 0.
- Starvation counter (2-bit):
  - Increments, saturating at `STARVE_MAX`, when B is valid and not granted.
  - Clears when B is granted or B is not valid.
- Scoreboard:
  - `clr` = one-hot(`o_rw`) when `o_rw_en` is high.
  - `eff` = `pending & ~clr`. The register file forwards same-cycle write data to its reads, so a register completing this cycle is not a hazard.
- Stall condition: `o_iss_stall` = `i_iss_valid` and any of:
  - (`i_iss_rx_used` and `eff[rx]`)
  - (`i_iss_ry_used` and `eff[ry]`)
  - (`i_iss_wen` and `eff[rw]`)
- Issue: when `i_iss_valid & i_iss_wen & ~o_iss_stall`, set `pending[rw]`.
- Next-state update: `pending_next = (pending & ~clr) | set`. If set and clr hit the same index in one cycle, set wins.
- Error: a grant with `pending[o_rw] == 0` sets `o_err`. It is cleared only by reset. The write still proceeds.
- r7 (PC) is scoreboarded like any other register; no special case.

## Timing
- Grants, write port and stall are combinational from the current inputs and state, with zero latency.
- `pending`, `starve_cnt` and `o_err` update on the rising edge of `clk`.
- A write issued in cycle n can be granted in cycle n+1 at the earliest.
- Requester handshake: a requester holds `valid`/`rw`/`data` stable until it sees `ready`. The transfer occurs in the cycle where `valid & ready`.
- While `reset` is high:
  - `o_a_ready`, `o_b_ready` and `o_rw_en` are 0.
  - `o_iss_stall` is 1.
- After the reset edge:
  - `pending` = 0, `starve_cnt` = 0, `o_err` = 0.
  - `o_rw` and `o_rw_data` = 0.
- Reset mid-operation discards all in-flight scoreboard state. Requesters must drop `valid` on reset.
- Worst-case B latency is `STARVE_MAX` + 1 cycles under continuous A traffic.

## Structure
- Package `cpu_pkg`:
  - `REG_N` = 8, `REG_IDX_W` = 3, `DATA_W` = 16
  - typedef `reg_idx_t` (logic [2:0])
  - typedef `wr_req_t` struct {valid, rw, data}
- Sub-module `cpu_wr_arbiter`: the two-way arbiter plus starvation counter. Its outputs are `grant_a`, `grant_b` and the muxed write.
- Scoreboard and stall logic live in the top module.

## Test plan
- Reset, then issue `wen` with rw=3 → next cycle `o_pending` = 8'h08, `o_iss_stall` = 0 during the issue cycle.
- With r3 pending, issue with rx=3, rx_used=1 → stall = 1. In the same cycle A writes r3 = 16'hBEEF → stall = 0, `o_rw_en` = 1, `o_rw` = 3, `o_pending` = 0 next cycle.
- A and B both valid continuously, `STARVE_MAX` = 2 → grant sequence A, A, B, A, A, B; each B grant after 2 denials; `starve_cnt` returns to 0.
- Same-cycle grant of r5 and issue `wen` rw=5 → no stall, `pending[5]` = 1 afterwards (set wins).
- Grant A write to r2 with `o_pending` = 0 → `o_err` = 1 next cycle, write still asserted, `o_err` stays 1 until reset.
- Reset asserted mid-traffic with pending = 8'hA5 → in the reset cycle readies = 0, stall = 1; afterwards pending = 0, `o_err` = 0.
